// File: rtl/req_axi_bridge.sv
// req_axi_bridge: cache native request port to a single-ID AXI4 master.
// One INCR burst (read or write) in flight at a time, 32-bit beats.
module req_axi_bridge #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              M_REQ,
    input  logic              M_WEN,
    input  logic [ADDR_W-1:0] M_ADDR,
    input  logic [7:0]        M_LEN,
    input  logic [DATA_W-1:0] M_WDATA,
    input  logic              M_WVALID,
    output logic              S_RDY,
    output logic              S_VALID,
    output logic [DATA_W-1:0] S_RDATA,
    output logic              S_WRDY,
    output logic              S_ERR,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [7:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY,
    output logic [ADDR_W-1:0] AWADDR,
    output logic [7:0]        AWLEN,
    output logic [2:0]        AWSIZE,
    output logic [1:0]        AWBURST,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [DATA_W-1:0] WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic              WLAST,
    output logic              WVALID,
    input  logic              WREADY,
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY
);

    typedef enum logic [2:0] {
        IDLE,
        AR_SEND,
        R_DATA,
        AW_SEND,
        W_DATA,
        B_WAIT,
        ERR_DONE
    } state_t;

    state_t            state;
    logic [7:0]        cnt;
    logic [7:0]        last_idx;
    logic              w_act;
    logic              at_last;
    logic              accept;
    logic [ADDR_W-1:0] aligned;

    assign aligned = {M_ADDR[ADDR_W-1:2], 2'b00};
    assign accept  = S_RDY & M_REQ;
    assign at_last = (cnt == last_idx);

    // Data beats pass straight through; gating flags are registered.
    assign S_VALID = RREADY & RVALID;
    assign S_RDATA = RREADY ? RDATA : '0;
    assign WVALID  = w_act & M_WVALID;
    assign WDATA   = w_act ? M_WDATA : '0;
    assign WSTRB   = {(DATA_W/8){w_act}};
    assign WLAST   = w_act & at_last;
    assign S_WRDY  = WVALID & WREADY;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state    <= IDLE;
            cnt      <= '0;
            last_idx <= '0;
            w_act    <= 1'b0;
            S_RDY    <= 1'b1;
            S_ERR    <= 1'b0;
            ARADDR   <= '0;
            ARLEN    <= '0;
            ARSIZE   <= '0;
            ARBURST  <= '0;
            ARVALID  <= 1'b0;
            RREADY   <= 1'b0;
            AWADDR   <= '0;
            AWLEN    <= '0;
            AWSIZE   <= '0;
            AWBURST  <= '0;
            AWVALID  <= 1'b0;
            BREADY   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // Also re-raises S_RDY one cycle after ERR_DONE.
                    S_RDY <= 1'b1;
                    if (accept) begin
                        S_RDY    <= 1'b0;
                        cnt      <= '0;
                        last_idx <= M_LEN - 8'd1;
                        S_ERR    <= (M_LEN == 8'd0) || (M_ADDR[1:0] != 2'b00);
                        if (M_LEN == 8'd0) begin
                            state <= ERR_DONE;
                        end else if (M_WEN) begin
                            state   <= AW_SEND;
                            AWVALID <= 1'b1;
                            AWADDR  <= aligned;
                            AWLEN   <= M_LEN - 8'd1;
                            AWSIZE  <= 3'b010;
                            AWBURST <= 2'b01;
                        end else begin
                            state   <= AR_SEND;
                            ARVALID <= 1'b1;
                            ARADDR  <= aligned;
                            ARLEN   <= M_LEN - 8'd1;
                            ARSIZE  <= 3'b010;
                            ARBURST <= 2'b01;
                        end
                    end
                end
                AR_SEND: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        state   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (RVALID && RREADY) begin
                        if (RRESP != 2'b00 || RLAST != at_last) begin
                            S_ERR <= 1'b1;
                        end
                        cnt <= cnt + 8'd1;
                        if (at_last) begin
                            RREADY <= 1'b0;
                            S_RDY  <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                end
                AW_SEND: begin
                    if (AWREADY) begin
                        AWVALID <= 1'b0;
                        w_act   <= 1'b1;
                        state   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (WVALID && WREADY) begin
                        cnt <= cnt + 8'd1;
                        if (at_last) begin
                            w_act  <= 1'b0;
                            BREADY <= 1'b1;
                            state  <= B_WAIT;
                        end
                    end
                end
                B_WAIT: begin
                    if (BVALID) begin
                        if (BRESP != 2'b00) begin
                            S_ERR <= 1'b1;
                        end
                        BREADY <= 1'b0;
                        S_RDY  <= 1'b1;
                        state  <= IDLE;
                    end
                end
                ERR_DONE: begin
                    S_ERR <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
